// File: rtl/nor3_pkg.sv
// Shared definitions for the 3-input NOR stimulus/check slice: widths, state
// encoding and the reference NOR function.
package nor3_pkg;

   localparam int unsigned VEC_W = 3;
   localparam int unsigned CNT_W = 4;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_SETTLE = 2'd1;
   localparam logic [1:0] ST_SAMPLE = 2'd2;
   localparam logic [1:0] ST_DONE   = 2'd3;

   typedef enum logic [1:0] {
      StIdle   = ST_IDLE,
      StSettle = ST_SETTLE,
      StSample = ST_SAMPLE,
      StDone   = ST_DONE
   } state_e;

   function automatic logic nor3_exp(input logic [VEC_W-1:0] vec);
      return ~|vec;
   endfunction

endpackage

// File: rtl/nor3_settle_timer.sv
// Settle down-counter: load arms it for SETTLE cycles, expire flags the last
// cycle of the settle window.
module nor3_settle_timer
   import nor3_pkg::*;
#(
   parameter int unsigned SETTLE = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic load,
   input  logic en,
   output logic expire
);

   // Counting SETTLE-1 down to 0 gives exactly SETTLE cycles in the window.
   localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(SETTLE - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = LOAD_VAL;
      end else if (en && (cnt_q != '0)) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expire = (cnt_q == '0);

endmodule

// File: rtl/nor3_vector_driver.sv
// Drives all eight {a,b,c} vectors into the NOR stage, checks f_in against the
// expected NOR, and reports mismatch count, first failing vector and done.
module nor3_vector_driver
   import nor3_pkg::*;
#(
   parameter int unsigned SETTLE = 2,
   parameter int unsigned PASSES = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   output logic             a,
   output logic             b,
   output logic             c,
   input  logic             f_in,
   output logic             busy,
   output logic             done,
   output logic             err,
   output logic [CNT_W-1:0] err_cnt,
   output logic [VEC_W-1:0] fail_vec,
   output logic [VEC_W-1:0] vec_idx
);

   localparam logic [1:0] LAST_PASS = 2'(PASSES - 1);

   state_e           state_q, state_d;
   logic [VEC_W-1:0] vec_q, vec_d;
   logic [VEC_W-1:0] fail_vec_q, fail_vec_d;
   logic [1:0]       pass_q, pass_d;
   logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             err_q, err_d;
   logic             timer_load;
   logic             timer_expire;
   logic             mismatch;

   nor3_settle_timer #(
      .SETTLE (SETTLE)
   ) u_settle_timer (
      .clk    (clk),
      .rst_n  (rst_n),
      .load   (timer_load),
      .en     (state_q == StSettle),
      .expire (timer_expire)
   );

   assign mismatch = (f_in != nor3_exp(vec_q));

   always_comb begin
      state_d    = state_q;
      vec_d      = vec_q;
      fail_vec_d = fail_vec_q;
      pass_d     = pass_q;
      err_cnt_d  = err_cnt_q;
      busy_d     = busy_q;
      done_d     = done_q;
      err_d      = err_q;
      timer_load = 1'b0;

      unique case (state_q)
         StIdle, StDone: begin
            if (start) begin
               state_d    = StSettle;
               busy_d     = 1'b1;
               done_d     = 1'b0;
               err_d      = 1'b0;
               err_cnt_d  = '0;
               fail_vec_d = '0;
               vec_d      = '0;
               pass_d     = '0;
               timer_load = 1'b1;
            end
         end
         StSettle: begin
            if (timer_expire) begin
               state_d = StSample;
            end
         end
         StSample: begin
            if (mismatch) begin
               err_d = 1'b1;
               if (err_cnt_q != '1) begin
                  err_cnt_d = err_cnt_q + 1'b1;
               end
               // Only the first failure of a run is latched.
               if (!err_q) begin
                  fail_vec_d = vec_q;
               end
            end
            if (vec_q == '1) begin
               vec_d = '0;
               if (pass_q == LAST_PASS) begin
                  state_d = StDone;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
               end else begin
                  pass_d     = pass_q + 1'b1;
                  state_d    = StSettle;
                  timer_load = 1'b1;
               end
            end else begin
               vec_d      = vec_q + 1'b1;
               state_d    = StSettle;
               timer_load = 1'b1;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         vec_q      <= '0;
         fail_vec_q <= '0;
         pass_q     <= '0;
         err_cnt_q  <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         vec_q      <= vec_d;
         fail_vec_q <= fail_vec_d;
         pass_q     <= pass_d;
         err_cnt_q  <= err_cnt_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         err_q      <= err_d;
      end
   end

   assign a        = vec_q[2];
   assign b        = vec_q[1];
   assign c        = vec_q[0];
   assign vec_idx  = vec_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign err      = err_q;
   assign err_cnt  = err_cnt_q;
   assign fail_vec = fail_vec_q;

endmodule
